// File: rtl/reg_32.sv
// Three-port register file: 32 x DATA_W, two combinational read ports, one
// clocked write port, r0 reads as zero. Define REG32_BYPASS_EN for write-through forwarding.
module reg_32 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [4:0]        ra,
    input  logic [4:0]        rb,
    input  logic [4:0]        wn,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb
);

    logic [DATA_W-1:0] regs [32];
    logic [31:0]       wr_sel;

    // One-hot write decode; entry 0 has no write path so r0 stays zero.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_wr_sel
            if (gi == 0) begin : g_zero
                assign wr_sel[gi] = 1'b0;
            end else begin : g_entry
                assign wr_sel[gi] = we && (wn == 5'(gi));
            end
        end
    endgenerate

    // An unknown enable makes the if condition false, so contents hold.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= d;
                end
            end
        end
    end

`ifdef REG32_BYPASS_EN
    logic byp_a;
    logic byp_b;

    assign byp_a = clrn && we && (wn != 5'd0) && (ra == wn);
    assign byp_b = clrn && we && (wn != 5'd0) && (rb == wn);
`endif

    always_comb begin
        qa = (ra == 5'd0) ? '0 : regs[ra];
        qb = (rb == 5'd0) ? '0 : regs[rb];
`ifdef REG32_BYPASS_EN
        if (byp_a) begin
            qa = d;
        end
        if (byp_b) begin
            qb = d;
        end
`endif
    end

endmodule

// File: tb/tb_reg_32.sv
// Bench for reg_32: reset sweep, directed vector table, hand sequences for
// async reset / bypass / unknown enable, then random traffic against a model.
module tb_reg_32;

    logic        clk;
    logic        clrn;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  wn;
    logic        we;
    logic [31:0] d;
    logic [31:0] qa;
    logic [31:0] qb;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [32];

`ifdef REG32_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reg_32 #(.DATA_W(32)) dut (
        .clk  (clk),
        .clrn (clrn),
        .ra   (ra),
        .rb   (rb),
        .wn   (wn),
        .we   (we),
        .d    (d),
        .qa   (qa),
        .qb   (qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wn;
        logic [31:0] d;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] eqa;
        logic [31:0] eqb;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%08h expected=%08h", name, act, exp);
        end
    endtask

    // Reference read: reset forces zero, forwarding (if built) wins, else stored value.
    function automatic logic [31:0] expect_q(input logic [4:0] a);
        if (clrn !== 1'b1) return 32'h0;
        if (BYP && we === 1'b1 && wn != 5'd0 && a == wn) return d;
        if (a == 5'd0) return 32'h0;
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic tick(input logic w, input logic [4:0] n, input logic [31:0] v);
        @(negedge clk);
        we = w;
        wn = n;
        d  = v;
        @(posedge clk);
        if (clrn === 1'b1 && w === 1'b1 && n != 5'd0) model[n] = v;
        #1;
        we = 1'b0;
    endtask

    initial begin
        clrn = 1'b1;
        we   = 1'b0;
        wn   = 5'd0;
        d    = 32'h0;
        ra   = 5'd0;
        rb   = 5'd0;
        clear_model();

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd13, 32'h12345678, 5'd13, 5'd5,  32'h12345678, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd13, 32'h00000000, 32'h12345678};
        vecs[3] = '{1'b0, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd0,  32'h00000000, 32'h00000000};
        vecs[4] = '{1'b1, 5'd7,  32'h0F0F0F0F, 5'd7,  5'd5,  32'h0F0F0F0F, 32'hDEADBEEF};
        vecs[5] = '{1'b0, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  32'h0F0F0F0F, 32'h0F0F0F0F};
        vecs[6] = '{1'b1, 5'd3,  32'h11111111, 5'd3,  5'd7,  32'h11111111, 32'h0F0F0F0F};
        vecs[7] = '{1'b1, 5'd4,  32'h22222222, 5'd3,  5'd4,  32'h11111111, 32'h22222222};
        vecs[8] = '{1'b0, 5'd4,  32'h33333333, 5'd4,  5'd3,  32'h22222222, 32'h11111111};
        vecs[9] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd1,  32'h80000001, 32'h00000000};

        // Reset sweep
        #2 clrn = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ra = 5'(a);
            rb = 5'(31 - a);
            #1;
            check($sformatf("reset_qa[%0d]", a), qa, 32'h0);
            check($sformatf("reset_qb[%0d]", 31 - a), qb, 32'h0);
        end
        $display("reset sweep: 64 reads");
        @(negedge clk);
        clrn = 1'b1;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            tick(vecs[i].we, vecs[i].wn, vecs[i].d);
            ra = vecs[i].ra;
            rb = vecs[i].rb;
            #1;
            check($sformatf("vec%0d_qa", i), qa, vecs[i].eqa);
            check($sformatf("vec%0d_qb", i), qb, vecs[i].eqb);
            $display("vec %0d: we=%0b wn=%0d d=%08h ra=%0d rb=%0d qa=%08h qb=%08h",
                     i, vecs[i].we, vecs[i].wn, vecs[i].d, ra, rb, qa, qb);
        end

        // Unknown enable must not modify r9
        tick(1'b1, 5'd9, 32'h00000011);
        @(negedge clk);
        we = 1'bx;
        wn = 5'd9;
        d  = 32'h0BADBAD0;
        ra = 5'd9;
        #1 check("xen_pre_edge", qa, 32'h00000011);
        @(posedge clk);
        #1 check("xen_post_edge", qa, 32'h00000011);
        we = 1'b0;
        #1 check("xen_hold", qa, 32'h00000011);
        $display("x-enable: r9=%08h", qa);

        // Same-cycle write/read of r9: forward or old value
        @(negedge clk);
        we = 1'b1;
        wn = 5'd9;
        d  = 32'hCAFEF00D;
        ra = 5'd9;
        rb = 5'd9;
        #1;
        check("byp_qa", qa, BYP ? 32'hCAFEF00D : 32'h00000011);
        check("byp_qb", qb, BYP ? 32'hCAFEF00D : 32'h00000011);
        @(posedge clk);
        model[9] = 32'hCAFEF00D;
        #1;
        we = 1'b0;
        #1 check("byp_after_edge", qa, 32'hCAFEF00D);
        $display("bypass: qa=%08h qb=%08h", qa, qb);

        // Async reset mid-cycle, write during reset lost, no resurrection after
        tick(1'b1, 5'd5, 32'hDEADBEEF);
        ra = 5'd5;
        rb = 5'd4;
        #1 check("ar_loaded", qa, 32'hDEADBEEF);
        @(negedge clk);
        #2 clrn = 1'b0;
        clear_model();
        #1 check("ar_qa_cleared", qa, 32'h0);
        check("ar_qb_cleared", qb, 32'h0);
        we = 1'b1;
        wn = 5'd5;
        d  = 32'h77777777;
        #1 check("ar_no_fwd_in_reset", qa, 32'h0);
        @(posedge clk);
        #1 check("ar_write_lost", qa, 32'h0);
        @(negedge clk);
        clrn = 1'b1;
        we   = 1'b0;
        @(posedge clk);
        #1 check("ar_stays_zero", qa, 32'h0);
        tick(1'b1, 5'd5, 32'h00000055);
        #1 check("ar_rewrite", qa, 32'h00000055);
        $display("async reset: r5=%08h", qa);

        // Random traffic against the model
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            clrn = ($urandom_range(0, 19) != 0);
            if (!clrn) clear_model();
            we = 1'($urandom_range(0, 1));
            wn = 5'($urandom);
            d  = $urandom;
            ra = ($urandom_range(0, 2) == 0) ? wn : 5'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom);
            #1;
            check($sformatf("rnd%0d_qa", it), qa, expect_q(ra));
            check($sformatf("rnd%0d_qb", it), qb, expect_q(rb));
            $display("rnd %0d: clrn=%0b we=%0b wn=%0d d=%08h ra=%0d qa=%08h rb=%0d qb=%08h",
                     it, clrn, we, wn, d, ra, qa, rb, qb);
            @(posedge clk);
            if (clrn && we && wn != 5'd0) model[wn] = d;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
